flash_stream: RTL and testbench
===============================

FLASH_STREAM -- requirements
Module: flash_stream

Interface
REQ-001 The module SHALL have parameter RETRY_MAX, default 255, meaning consecutive rty_i terminations tolerated before error.
REQ-002 The module SHALL have parameter RETRY_GAP, default 16, meaning idle clk_i cycles inserted between a rty_i and the re-issued request.
REQ-003 clk_i  in  1  single system clock (100 MHz); all logic on its rising edge.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 start_i  in  1  one-cycle pulse starting a stream; ignored while busy_o=1.
REQ-006 base_adr_i  in  24  flash byte address of first byte, sampled on start_i; bits [1:0] treated as 0.
REQ-007 len_i  in  24  stream length in bytes, sampled on start_i.
REQ-008 abort_i  in  1  terminates an active stream.
REQ-009 adr_o  out  24  word address to flash reader, bits [1:0]=0.
REQ-010 stb_o / we_o  out  1 / 1  request strobe / write enable (we_o constant 0).
REQ-011 dat_i  in  32  read word, first flash byte in [31:24].
REQ-012 ack_i / rty_i  in  1 / 1  request terminations from flash reader.
REQ-013 byte_o / valid_o  out  8 / 1  output byte stream and its valid.
REQ-014 ready_i  in  1  downstream accepts byte_o when valid_o && ready_i.
REQ-015 busy_o / done_o / err_o  out  1 / 1 / 1  stream active / stream completed (1-cycle pulse) / retry limit hit (level).

Function
REQ-016 States SHALL be IDLE, REQ, GAP, EMIT, ERR.
REQ-017 IDLE: start_i with len_i!=0 -> REQ with adr_o=base_adr_i&~3, remaining=len_i, err_o cleared; start_i with len_i==0 -> done_o pulse next cycle, stay IDLE.
REQ-018 stb_o SHALL be registered, asserted the cycle after entering REQ, held until ack_i or rty_i sampled high, then low for at least one cycle before any re-assertion.
REQ-019 REQ on ack_i: latch dat_i into word buffer, clear retry count, set byte index 0, -> EMIT.
REQ-020 REQ on rty_i: increment retry count; if new count > RETRY_MAX -> ERR, else -> GAP.
REQ-021 GAP SHALL wait exactly RETRY_GAP cycles with stb_o=0, then -> REQ at the same adr_o.
REQ-022 EMIT: byte_o = buffer byte (index 0 = [31:24] .. 3 = [7:0]); valid_o registered; byte_o stable while valid_o && !ready_i.
REQ-023 Each accepted byte SHALL decrement remaining; remaining reaching 0 -> valid_o drops, done_o pulses, -> IDLE, even mid-word.
REQ-024 After byte index 3 accepted with remaining!=0: adr_o += 4 (wraps modulo 2^24) -> REQ; no prefetch.
REQ-025 ERR: stb_o=0, valid_o=0, err_o=1, busy_o=0; start_i accepted exactly as in IDLE.
REQ-026 abort_i in any non-IDLE state SHALL, next cycle, force stb_o=0, valid_o=0, -> IDLE, no done_o; abort has priority over simultaneous ack_i/rty_i.
REQ-027 busy_o SHALL equal 1 in REQ, GAP, EMIT.
REQ-028 ack_i/rty_i sampled while stb_o=0 SHALL be ignored.

Reset
REQ-029 rst_ni low SHALL asynchronously force IDLE, stb_o=0, we_o=0, adr_o=0, valid_o=0, byte_o=0, busy_o=0, done_o=0, err_o=0, counters 0.
REQ-030 Reset mid-request SHALL drop stb_o immediately; no transaction resumes on release.

Structure
REQ-031 State enum, RETRY_MAX/RETRY_GAP defaults and flash command constants SHALL live in shared package flash_pkg.
REQ-032 Byte unpacking (buffer, index, valid/ready) MAY be sub-module word_unpacker; the rest is one FSM.

Verification
REQ-033 base=0x000100, len=6, slave acks 0x11223344, 0x55667788, ready_i=1 -> bytes 11 22 33 44 55 66, adr_o 0x000100 then 0x000104, one done_o.
REQ-034 len=4, ready_i low 10 cycles after valid_o -> byte_o holds 0x11 steady, no stb_o until all 4 accepted.
REQ-035 RETRY_MAX=2, slave rty 2x then ack -> 2 GAP periods of 16 cycles, stream completes, err_o=0.
REQ-036 RETRY_MAX=2, slave rty 3x -> err_o=1, busy_o=0, no bytes emitted; next start_i clears err_o.
REQ-037 abort_i coincident with ack_i -> stb_o=0 next cycle, valid_o never asserted, no done_o.
REQ-038 rst_ni low while stb_o=1 -> stb_o=0 within same cycle; len_i=0 start -> done_o only, stb_o never high.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared types and constants for the flash byte-stream reader.
package flash_pkg;

  localparam int ADR_W         = 24;
  localparam int RETRY_MAX_DEF = 255;
  localparam int RETRY_GAP_DEF = 16;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    EMIT,
    ERR
  } stream_state_e;

  // Flash byte order is big-endian within a word: index 0 is the first byte.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] sel;
    case (idx)
      2'd0:    sel = word[31:24];
      2'd1:    sel = word[23:16];
      2'd2:    sel = word[15:8];
      default: sel = word[7:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/word_unpacker.sv
// Holds one fetched word and hands it downstream a byte at a time over valid/ready.
module word_unpacker
  import flash_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] word,
  input  logic        ready,
  output logic [7:0]  data_byte,
  output logic        valid,
  output logic [1:0]  index,
  output logic        fire
);

  logic [31:0] buffer;

  assign fire      = valid && ready;
  assign data_byte = word_byte(buffer, index);

  // Flush wins over everything so an abort or stream end drops valid at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buffer <= '0;
      index  <= '0;
      valid  <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      buffer <= word;
      index  <= 2'd0;
      valid  <= 1'b1;
    end else if (fire) begin
      index <= index + 2'd1;
      if (index == 2'd3) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/flash_stream.sv
// Streams a byte range out of flash: one word request at a time, retried with a gap on rty_i.
// RETRY_GAP is expected to be at least 1.
module flash_stream
  import flash_pkg::*;
#(
  parameter int RETRY_MAX = RETRY_MAX_DEF,
  parameter int RETRY_GAP = RETRY_GAP_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADR_W-1:0]  base_adr_i,
  input  logic [ADR_W-1:0]  len_i,
  input  logic              abort_i,
  output logic [ADR_W-1:0]  adr_o,
  output logic              stb_o,
  output logic              we_o,
  input  logic [31:0]       dat_i,
  input  logic              ack_i,
  input  logic              rty_i,
  output logic [7:0]        byte_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(RETRY_GAP - 1);

  stream_state_e    state, state_next;
  logic [ADR_W-1:0] adr_q, remaining;
  logic [RW-1:0]    retry_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             stb_q, done_q, err_q;
  logic             load, flush, fire;
  logic [1:0]       unp_idx;

  logic aborting, start_ok, took_ack, took_rty, retry_full, emit_fire, last_byte;

  // Terminations only count while the strobe is really out; abort beats them all.
  assign aborting   = abort_i && (state != IDLE);
  assign start_ok   = start_i && ((state == IDLE) || (state == ERR)) && !aborting;
  assign took_ack   = (state == REQ) && stb_q && ack_i && !aborting;
  assign took_rty   = (state == REQ) && stb_q && rty_i && !ack_i && !aborting;
  assign retry_full = retry_cnt >= RW'(RETRY_MAX);
  assign emit_fire  = (state == EMIT) && fire && !aborting;
  assign last_byte  = (remaining == 24'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (aborting) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, ERR: if (start_ok) state_next = (len_i != '0) ? REQ : IDLE;
        REQ: begin
          if (took_ack)      state_next = EMIT;
          else if (took_rty) state_next = retry_full ? ERR : GAP;
        end
        GAP:  if (gap_cnt == GAP_LAST) state_next = REQ;
        EMIT: begin
          if (emit_fire) begin
            if (last_byte)              state_next = IDLE;
            else if (unp_idx == 2'd3)   state_next = REQ;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o = 1'b0;
    load   = took_ack;
    flush  = aborting || (emit_fire && last_byte);
    if ((state == REQ) || (state == GAP) || (state == EMIT)) busy_o = 1'b1;
  end

  // The strobe rises one cycle into REQ and falls as soon as REQ is left, which
  // guarantees a low cycle before every re-issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      adr_q     <= '0;
      remaining <= '0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      stb_q   <= (state == REQ) && (state_next == REQ);
      done_q  <= (start_ok && (len_i == '0)) || (emit_fire && last_byte);
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;

      if (start_ok)                    err_q <= 1'b0;
      else if (took_rty && retry_full) err_q <= 1'b1;

      if (start_ok || took_ack) retry_cnt <= '0;
      else if (took_rty)        retry_cnt <= retry_cnt + 1'b1;

      if (start_ok && (len_i != '0)) begin
        adr_q     <= base_adr_i & ~24'h3;
        remaining <= len_i;
      end else if (emit_fire) begin
        remaining <= remaining - 24'd1;
        if (!last_byte && (unp_idx == 2'd3)) adr_q <= adr_q + 24'd4;
      end
    end
  end

  assign adr_o = adr_q;
  assign stb_o = stb_q;
  assign we_o  = 1'b0;
  assign done_o = done_q;
  assign err_o  = err_q;

  word_unpacker u_unpacker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load      (load),
    .flush     (flush),
    .word      (dat_i),
    .ready     (ready_i),
    .data_byte (byte_o),
    .valid     (valid_o),
    .index     (unp_idx),
    .fire      (fire)
  );

endmodule

// File: tb/tb_flash_stream.sv
// Randomized bench for flash_stream: a flash slave, a downstream sink and a byte-range reference model.
module tb_flash_stream;

  localparam int RMAX = 2;
  localparam int RGAP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ack = 1'b0;
  logic        rty = 1'b0;
  logic        ready = 1'b0;
  logic [23:0] base_adr = '0;
  logic [23:0] len = '0;
  logic [31:0] dat = '0;

  logic [23:0] adr_o;
  logic        stb_o, we_o, valid_o, busy_o, done_o, err_o;
  logic [7:0]  byte_o;

  int tests = 0;
  int fails = 0;

  int         cfg_gen = 0;
  int         rty_cfg = 0;
  int         ready_pct = 100;
  int         hold_cfg = 0;
  bit         mute = 1'b0;
  bit         abort_on_ack = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  logic [7:0]  got_bytes[$];
  logic [23:0] got_adrs[$];
  int          gaps[$];
  int          done_cnt, valid_cnt, stb_cnt, hold_bad, hold_cycles;

  flash_stream #(.RETRY_MAX(RMAX), .RETRY_GAP(RGAP)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .base_adr_i (base_adr),
    .len_i      (len),
    .abort_i    (abort),
    .adr_o      (adr_o),
    .stb_o      (stb_o),
    .we_o       (we_o),
    .dat_i      (dat),
    .ack_i      (ack),
    .rty_i      (rty),
    .byte_o     (byte_o),
    .valid_o    (valid_o),
    .ready_i    (ready),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Flash contents: the two words used by the directed case, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [23:0] a);
    if (a == 24'h000100) return 32'h11223344;
    if (a == 24'h000104) return 32'h55667788;
    return {a[7:0] ^ 8'hA5, a[15:8] + 8'h3C, a[23:16] ^ a[9:2], ~a[7:0]};
  endfunction

  // The i-th streamed byte is simply flash byte (aligned base + i).
  function automatic logic [7:0] model_byte(input logic [23:0] b, input int i);
    logic [23:0] a;
    logic [31:0] w;
    a = (b & ~24'h3) + 24'(i);
    w = mem_word(a & ~24'h3);
    return w[8*(3-int'(a[1:0])) +: 8];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] b, input logic [23:0] l);
    @(negedge clk);
    base_adr = b;
    len      = l;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic newConfig(input int rtys, input int pct, input int hold, input bit m, input bit aoa);
    rty_cfg      = rtys;
    ready_pct    = pct;
    hold_cfg     = hold;
    mute         = m;
    abort_on_ack = aoa;
    cfg_gen++;
    repeat (2) @(negedge clk);
  endtask

  task automatic waitEnd(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && !err_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stream_end", 32'((done_cnt != 0) || err_o), 32'd1);
  endtask

  task automatic checkStream(input logic [23:0] b, input logic [23:0] l);
    int          lim, nwords;
    logic [23:0] exp_adr;
    lim = (got_bytes.size() < int'(l)) ? got_bytes.size() : int'(l);
    checkOutput("byte_count", got_bytes.size(), 32'(l));
    for (int i = 0; i < lim; i++) checkOutput("byte", got_bytes[i], model_byte(b, i));
    nwords = (int'(l) + 3) / 4;
    checkOutput("req_count", got_adrs.size(), nwords);
    for (int k = 0; k < nwords && k < got_adrs.size(); k++) begin
      exp_adr = (b & ~24'h3) + 24'(4 * k);
      checkOutput("adr", got_adrs[k], exp_adr);
    end
    checkOutput("done_count", done_cnt, 1);
    checkOutput("err_after_stream", err_o, 0);
  endtask

  task automatic runStream(input logic [23:0] b, input logic [23:0] l, input int rtys, input int pct, input int hold);
    newConfig(rtys, pct, hold, 1'b0, 1'b0);
    applyStimulus(b, l);
    waitEnd(3000);
    repeat (6) @(negedge clk);
    checkStream(b, l);
  endtask

  // Slave, sink and monitor in one process so every input change and every
  // observation happens in a fixed order on the falling edge.
  initial begin
    int seen_gen, rty_left, lat, lat_tgt, hold_left, gap_run;
    bit in_gap;
    seen_gen = -1;
    rty_left = 0; lat = 0; lat_tgt = 0; hold_left = 0; gap_run = 0; in_gap = 1'b0;
    forever begin
      @(negedge clk);
      if (cfg_gen != seen_gen) begin
        seen_gen = cfg_gen;
        got_bytes.delete(); got_adrs.delete(); gaps.delete();
        done_cnt = 0; valid_cnt = 0; stb_cnt = 0; hold_bad = 0; hold_cycles = 0;
        rty_left = rty_cfg; hold_left = hold_cfg; lat = 0; lat_tgt = 0; in_gap = 1'b0;
      end
      ack = 1'b0; rty = 1'b0; abort = 1'b0;
      if (done_o)  done_cnt++;
      if (valid_o) valid_cnt++;
      if (stb_o)   stb_cnt++;
      if (in_gap) begin
        if (stb_o) begin
          in_gap = 1'b0;
          gaps.push_back(gap_run);
        end else gap_run++;
      end
      if (valid_o && hold_left > 0) begin
        ready = 1'b0;
        hold_left--;
        hold_cycles++;
        if (byte_o !== hold_byte || stb_o) hold_bad++;
      end else begin
        ready = ($urandom_range(0, 99) < ready_pct);
      end
      if (valid_o && ready) got_bytes.push_back(byte_o);
      if (stb_o && !mute) begin
        if (lat < lat_tgt) lat++;
        else begin
          lat = 0;
          lat_tgt = $urandom_range(0, 2);
          if (rty_left > 0) begin
            rty = 1'b1;
            rty_left--;
            in_gap = 1'b1;
            gap_run = 0;
          end else begin
            ack = 1'b1;
            dat = mem_word(adr_o);
            got_adrs.push_back(adr_o);
            rty_left = rty_cfg;
            abort = abort_on_ack;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got time limit, expected completion");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [23:0] b, l;

    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_stb", stb_o, 0);
    checkOutput("rst_we", we_o, 0);
    checkOutput("rst_adr", adr_o, 0);
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_byte", byte_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_err", err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-word stream with known data.
    runStream(24'h000100, 24'd6, 0, 100, 0);

    // Downstream stall on the first byte.
    hold_byte = 8'h11;
    runStream(24'h000100, 24'd4, 0, 100, 10);
    checkOutput("hold_cycles", hold_cycles, 10);
    checkOutput("hold_steady", hold_bad, 0);

    // Two retries per word stay under the limit.
    runStream(24'h000200, 24'd6, 2, 100, 0);
    checkOutput("gap_count", gaps.size(), 4);
    for (int i = 0; i < gaps.size(); i++) checkOutput("gap_len", gaps[i], RGAP + 1);

    // Third retry trips the error.
    newConfig(3, 100, 0, 1'b0, 1'b0);
    applyStimulus(24'h000300, 24'd8);
    waitEnd(500);
    repeat (3) @(negedge clk);
    checkOutput("err_level", err_o, 1);
    checkOutput("err_busy", busy_o, 0);
    checkOutput("err_stb", stb_o, 0);
    checkOutput("err_bytes", got_bytes.size(), 0);
    checkOutput("err_valid_cnt", valid_cnt, 0);
    newConfig(0, 100, 0, 1'b0, 1'b0);
    applyStimulus(24'h000300, 24'd4);
    checkOutput("err_cleared", err_o, 0);
    checkOutput("restart_busy", busy_o, 1);
    waitEnd(500);
    repeat (6) @(negedge clk);
    checkStream(24'h000300, 24'd4);

    // Abort lands on the same edge as the ack.
    newConfig(0, 100, 0, 1'b0, 1'b1);
    applyStimulus(24'h000400, 24'd8);
    n = 0;
    while (got_adrs.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_ack_seen", 32'(got_adrs.size() != 0), 1);
    @(posedge clk);
    #1;
    checkOutput("abort_stb", stb_o, 0);
    checkOutput("abort_busy", busy_o, 0);
    repeat (20) @(negedge clk);
    checkOutput("abort_valid_cnt", valid_cnt, 0);
    checkOutput("abort_done_cnt", done_cnt, 0);

    // Reset in the middle of an outstanding request.
    newConfig(0, 100, 0, 1'b1, 1'b0);
    applyStimulus(24'h000500, 24'd8);
    n = 0;
    while (!stb_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stb_before_reset", stb_o, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_stb", stb_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_adr", adr_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    newConfig(0, 100, 0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("no_resume_stb", stb_cnt, 0);
    checkOutput("no_resume_busy", busy_o, 0);

    // Zero-length start only pulses done.
    newConfig(0, 100, 0, 1'b0, 1'b0);
    applyStimulus(24'h000600, 24'd0);
    repeat (5) @(negedge clk);
    checkOutput("len0_done_cnt", done_cnt, 1);
    checkOutput("len0_stb_cnt", stb_cnt, 0);
    checkOutput("len0_busy", busy_o, 0);

    // Random ranges, some crossing the top of the address space.
    for (int t = 0; t < 8; t++) begin
      b = 24'($urandom);
      if (t % 3 == 0) b = 24'hFFFFF8 | 24'($urandom_range(0, 7));
      l = 24'($urandom_range(1, 14));
      runStream(b, l, $urandom_range(0, 2), $urandom_range(40, 100), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
